// File: rtl/instr_fetch.sv
// instr_fetch: initiator side of the instruction-memory read port.
// Owns the program counter, samples the combinational ROM word for the
// current pc, and queues {pc, inst} pairs in a 2-entry in-order buffer that
// feeds decode over a valid/ready handshake. A redirect flushes the buffer
// and reloads the pc. An all-zero word stops fetching until a redirect.
//
// Ports:
//   clk            - clock, rising-edge active
//   rst_n          - asynchronous active-low reset
//   pc             - fetch address to instruction memory (registered)
//   inst           - instruction word for pc (combinational from memory)
//   redirect_valid - load redirect_pc into the pc this cycle
//   redirect_pc    - redirect target (low two bits ignored)
//   out_valid      - buffer head holds a valid instruction
//   out_ready      - decode accepts the head this cycle
//   out_inst       - head instruction word
//   out_pc         - pc of the head instruction
//   halted         - fetch stopped on a zero word
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;
  localparam logic [31:0] STEP        = 32'(PC_STEP);

  state_e      state_q;
  logic        halted_q;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  // Entry 0 is the head and drives the outputs directly.
  logic [31:0] e0_pc_q, e0_pc_d, e0_inst_q, e0_inst_d;
  logic [31:0] e1_pc_q, e1_pc_d, e1_inst_q, e1_inst_d;

  logic pop, fire, push, zero_hit;

  assign pop      = (cnt_q != 2'd0) & out_ready;
  assign fire     = (state_q == RUN) & ~redirect_valid & ((cnt_q != 2'd2) | pop);
  assign push     = fire & (inst != 32'd0);
  assign zero_hit = fire & (inst == 32'd0);

  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    e0_pc_d   = e0_pc_q;
    e0_inst_d = e0_inst_q;
    e1_pc_d   = e1_pc_q;
    e1_inst_d = e1_inst_q;
    if (redirect_valid) begin
      // Flush wins over any concurrent pop; stale data stays but is invalid.
      cnt_d = 2'd0;
      pc_d  = redirect_pc & ~32'h3;
    end else begin
      if (push) pc_d = pc_q + STEP;
      if (pop && push) begin
        if (cnt_q == 2'd2) begin
          e0_pc_d   = e1_pc_q;
          e0_inst_d = e1_inst_q;
          e1_pc_d   = pc_q;
          e1_inst_d = inst;
        end else begin
          e0_pc_d   = pc_q;
          e0_inst_d = inst;
        end
      end else if (pop) begin
        // Shifting entry 1 forward is harmless when it is empty.
        e0_pc_d   = e1_pc_q;
        e0_inst_d = e1_inst_q;
        cnt_d     = cnt_q - 2'd1;
      end else if (push) begin
        if (cnt_q == 2'd0) begin
          e0_pc_d   = pc_q;
          e0_inst_d = inst;
        end else begin
          e1_pc_d   = pc_q;
          e1_inst_d = inst;
        end
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC_AL;
      cnt_q     <= 2'd0;
      e0_pc_q   <= 32'd0;
      e0_inst_q <= 32'd0;
      e1_pc_q   <= 32'd0;
      e1_inst_q <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      e0_pc_q   <= e0_pc_d;
      e0_inst_q <= e0_inst_d;
      e1_pc_q   <= e1_pc_d;
      e1_inst_q <= e1_inst_d;
    end
  end

  // Run/halt control with registered halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (!redirect_valid && zero_hit) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          if (redirect_valid) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_inst  = e0_inst_q;
  assign out_pc    = e0_pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [31:0] pc, inst, pc2, inst2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready, halted;
  logic [31:0] out_inst, out_pc;
  logic        out_valid2, halted2;
  logic [31:0] out_inst2, out_pc2;

  logic [31:0] rom [64];

  int checks = 0;
  int errs   = 0;

  // Reference model state: what the buffer must contain, per the fetch rules.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic [31:0] mpc;
  logic        mhalt;

  logic [31:0] pop_log[$];
  logic [31:0] last_pc, last_inst;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    if (a < 32'd256) return rom[a[7:2]];
    return 32'h0000_0013;
  endfunction

  assign inst  = rom_f(pc);
  assign inst2 = rom_f(pc2);

  instr_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .halted(halted)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .pc(pc2), .inst(inst2),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .out_valid(out_valid2), .out_ready(1'b1),
    .out_inst(out_inst2), .out_pc(out_pc2), .halted(halted2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_inst.delete();
    mpc   = 32'd0;
    mhalt = 1'b0;
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_next(input logic rv, input logic [31:0] rpc, input logic rdy);
    int n;
    logic pop_m, fire_m;
    logic [31:0] w;
    n = mq_pc.size();
    if (rv) begin
      mq_pc.delete();
      mq_inst.delete();
      mpc   = {rpc[31:2], 2'b00};
      mhalt = 1'b0;
    end else begin
      pop_m  = (n > 0) && rdy;
      fire_m = !mhalt && ((n < 2) || pop_m);
      if (pop_m) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (fire_m) begin
        w = rom_f(mpc);
        if (w != 32'd0) begin
          mq_pc.push_back(mpc);
          mq_inst.push_back(w);
          mpc = mpc + 32'd4;
        end else begin
          mhalt = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    chk("pc", pc, mpc);
    chk("halted", {31'd0, halted}, {31'd0, mhalt});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (mq_pc.size() > 0)});
    if (mq_pc.size() > 0) begin
      chk("out_pc", out_pc, mq_pc[0]);
      chk("out_inst", out_inst, mq_inst[0]);
    end
  endtask

  // Called just after a falling edge: drive inputs, clock once, check.
  task automatic tick(input logic rv, input logic [31:0] rpc, input logic rdy);
    if (out_valid && rdy && !rv) begin
      pop_log.push_back(out_pc);
      last_pc   = out_pc;
      last_inst = out_inst;
    end
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_next(rv, rpc, rdy);
    @(negedge clk);
    compare();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0013 + i;
    rom[0]  = 32'h0020_81b3;
    rom[1]  = 32'h4020_d3b3;
    rom[2]  = 32'h0020_92b3;
    rom[3]  = 32'h0020_f433;
    rom[12] = 32'h00b3_9e63;
    rom[15] = 32'h0030_d193;
    rom[16] = 32'h0000_0000;

    rst_n = 1'b0; rst2_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    last_pc = 32'hX; last_inst = 32'hX;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_pc", pc, 32'h0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_inst", out_inst, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
    compare();

    // Streaming with out_ready high.
    tick(1'b0, 32'd0, 1'b1);
    chk("stream1_pc", out_pc, 32'd0);
    chk("stream1_inst", out_inst, 32'h0020_81b3);
    tick(1'b0, 32'd0, 1'b1);
    chk("stream2_pc", out_pc, 32'd4);
    chk("stream2_inst", out_inst, 32'h4020_d3b3);
    tick(1'b0, 32'd0, 1'b1);
    chk("stream3_pc", out_pc, 32'd8);
    chk("stream3_inst", out_inst, 32'h0020_92b3);

    // Run into the zero word at 64.
    for (int i = 0; i < 17; i++) tick(1'b0, 32'd0, 1'b1);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc, 32'd64);
    chk("halt_drained", {31'd0, out_valid}, 32'd0);
    chk("halt_last_pc", last_pc, 32'd60);
    chk("halt_last_inst", last_inst, 32'h0030_d193);
    tick(1'b0, 32'd0, 1'b1);
    chk("halt_pc_hold", pc, 32'd64);

    // Redirect out of halt; then fill the buffer under backpressure.
    tick(1'b1, 32'h0000_000E, 1'b0);
    chk("redir_pc", pc, 32'd12);
    chk("redir_halted", {31'd0, halted}, 32'd0);
    tick(1'b0, 32'd0, 1'b0);
    chk("redir_out_pc", out_pc, 32'd12);
    chk("redir_out_inst", out_inst, 32'h0020_f433);
    tick(1'b0, 32'd0, 1'b0);
    tick(1'b0, 32'd0, 1'b0);
    chk("full_stall_pc", pc, 32'd20);
    chk("full_stable_pc", out_pc, 32'd12);

    // Redirect while full flushes the old entries.
    tick(1'b1, 32'h0000_0030, 1'b0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_pc", pc, 32'd48);
    tick(1'b0, 32'd0, 1'b1);
    chk("flush_out_pc", out_pc, 32'd48);
    chk("flush_out_inst", out_inst, 32'h00b3_9e63);

    // Halt again, then async reset between edges.
    for (int i = 0; i < 8; i++) tick(1'b0, 32'd0, 1'b1);
    chk("halt2_flag", {31'd0, halted}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_pc", pc, 32'd0);
    chk("areset_halted", {31'd0, halted}, 32'd0);
    chk("areset_valid", {31'd0, out_valid}, 32'd0);
    model_reset();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    compare();

    // Backpressure for 5 cycles, then release.
    for (int i = 0; i < 5; i++) tick(1'b0, 32'd0, 1'b0);
    chk("bp_pc_hold", pc, 32'd8);
    chk("bp_head", out_pc, 32'd0);
    pop_log.delete();
    for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 1'b1);
    chk("bp_pop_count", pop_log.size(), 32'd3);
    if (pop_log.size() == 3) begin
      chk("bp_pop0", pop_log[0], 32'd0);
      chk("bp_pop1", pop_log[1], 32'd4);
      chk("bp_pop2", pop_log[2], 32'd8);
    end

    // Wrap-around from RESET_PC = FFFF_FFFC.
    chk("wrap_reset_pc", pc2, 32'hFFFF_FFFC);
    rst2_n = 1'b1;
    @(negedge clk);
    chk("wrap_pc", pc2, 32'h0);
    chk("wrap_out_valid", {31'd0, out_valid2}, 32'd1);
    chk("wrap_out_pc", out_pc2, 32'hFFFF_FFFC);
    chk("wrap_out_inst", out_inst2, 32'h0000_0013);
    @(negedge clk);
    #2 rst2_n = 1'b0;
    #1;
    chk("wrap_areset_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_areset_valid", {31'd0, out_valid2}, 32'd0);
    chk("wrap_areset_halted", {31'd0, halted2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
